// File: rtl/vld_rdy_buf_arb_if.sv
// Handshake bundle between the requesters, the arbiter and the pairing buffer.
// master: the arbiter's view; slave: the surrounding environment (requesters + buffer).
interface vld_rdy_buf_arb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ)
);
    // valid/ready: a beat moves on every cycle where both are high at the rising edge;
    // a source holding valid keeps valid and data stable until it sees ready.
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          buf_valid;
    logic                          buf_ready;
    logic [DATA_WIDTH-1:0]         buf_data;
    logic                          buf_out_valid;
    logic                          buf_out_ready;
    logic [ID_WIDTH-1:0]           grp_id;
    logic                          busy;

    modport master (
        input  req_valid, req_data, buf_ready, buf_out_valid, buf_out_ready,
        output req_ready, buf_valid, buf_data, grp_id, busy
    );

    modport slave (
        output req_valid, req_data, buf_ready, buf_out_valid, buf_out_ready,
        input  req_ready, buf_valid, buf_data, grp_id, busy
    );
endinterface

// File: rtl/vld_rdy_buf_arb.sv
// Round-robin arbiter that locks onto one source for FIFO_DEPTH beats so every
// group packed by the downstream buffer comes from a single source, tagged by grp_id.
module vld_rdy_buf_arb #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int NUM_REQ    = 4,
    parameter int ID_WIDTH   = $clog2(NUM_REQ),
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
    input logic               clk,
    input logic               rstn,
    vld_rdy_buf_arb_if.master bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e               state_q, state_d;
    logic [ID_WIDTH-1:0]  rr_ptr_q, rr_ptr_d;
    logic [ID_WIDTH-1:0]  grant_q, grant_d;
    logic [CNT_WIDTH-1:0] beat_cnt_q, beat_cnt_d;
    logic [ID_WIDTH-1:0]  pend_id_q, pend_id_d;

    logic                 pick_found;
    logic [ID_WIDTH-1:0]  pick_id;
    logic [ID_WIDTH-1:0]  cand_id;
    logic                 beat_acc;

    // Cyclic search for the first valid source at or after rr_ptr.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand_id    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_id = (rr_ptr_q >= ID_WIDTH'(NUM_REQ - i)) ? rr_ptr_q - ID_WIDTH'(NUM_REQ - i)
                                                          : rr_ptr_q + ID_WIDTH'(i);
            if (!pick_found && bus.req_valid[cand_id]) begin
                pick_found = 1'b1;
                pick_id    = cand_id;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_ptr_d      = rr_ptr_q;
        grant_d       = grant_q;
        beat_cnt_d    = beat_cnt_q;
        pend_id_d     = pend_id_q;
        beat_acc      = 1'b0;
        bus.req_ready = '0;
        bus.buf_valid = 1'b0;
        bus.buf_data  = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    grant_d    = pick_id;
                    beat_cnt_d = '0;
                    state_d    = BURST;
                end
            end
            BURST: begin
                bus.buf_valid          = bus.req_valid[grant_q];
                bus.buf_data           = bus.req_data[grant_q*DATA_WIDTH +: DATA_WIDTH];
                bus.req_ready[grant_q] = bus.buf_ready;
                beat_acc               = bus.req_valid[grant_q] & bus.buf_ready;
                if (beat_acc) begin
                    beat_cnt_d = beat_cnt_q + CNT_WIDTH'(1);
                    if (beat_cnt_q == CNT_WIDTH'(FIFO_DEPTH - 1)) begin
                        // Group complete: the buffer turns full on this same edge,
                        // so the tag is ready exactly when master_valid rises.
                        pend_id_d = grant_q;
                        rr_ptr_d  = (grant_q == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_q + ID_WIDTH'(1);
                        state_d   = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            beat_cnt_q <= '0;
            pend_id_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            pend_id_q  <= pend_id_d;
        end
    end

    assign bus.grp_id = pend_id_q;
    assign bus.busy   = (state_q == BURST);

endmodule

// File: tb/tb_vld_rdy_buf_arb.sv
// Directed bench for vld_rdy_buf_arb: per-source beat queues drive the requesters,
// a small pairing-buffer model drives buf_ready, and a monitor scores beats and group tags.
module tb_vld_rdy_buf_arb;

    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [7:0]    gap;
    } beat_t;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    vld_rdy_buf_arb_if #(.DATA_WIDTH(DW), .NUM_REQ(NREQ), .ID_WIDTH(IDW)) bus ();

    vld_rdy_buf_arb #(
        .DATA_WIDTH(DW),
        .FIFO_DEPTH(DEPTH),
        .NUM_REQ   (NREQ),
        .ID_WIDTH  (IDW)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    beat_t          src_q[NREQ][$];
    logic [NREQ-1:0] cur_valid;
    logic [DW-1:0]  cur_data[NREQ];
    logic [DW-1:0]  exp_q[$];
    logic [IDW-1:0] gid_q[$];
    logic           stall;
    logic           drain;
    int             bm_cnt;
    int             n_checks;
    int             n_fails;
    int             acc_cnt;
    int             cyc;
    int             first_acc;
    int             last_acc;
    bit             meas_on;

    assign bus.req_valid = cur_valid;
    for (genvar g = 0; g < NREQ; g++) begin : g_data
        assign bus.req_data[g*DW +: DW] = cur_data[g];
    end
    // Pairing-buffer model: accepts while not full or while draining, presents only when full.
    assign bus.buf_ready     = !stall && ((bm_cnt != DEPTH) || drain);
    assign bus.buf_out_valid = (bm_cnt == DEPTH);
    assign bus.buf_out_ready = drain;

    function automatic logic [DW-1:0] mk(input int t, input int s, input int b);
        return {4'(t), 4'(s), 24'(b)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver + buffer model ----------------
    initial begin
        logic [NREQ-1:0] acc;
        logic            wr;
        logic            rd;
        beat_t           ent;
        forever begin
            @(posedge clk);
            acc = cur_valid & bus.req_ready;
            wr  = bus.buf_valid && bus.buf_ready;
            rd  = bus.buf_out_valid && bus.buf_out_ready;
            #1;
            if (rd) bm_cnt = wr ? 1 : 0;
            else if (wr) bm_cnt = bm_cnt + 1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    cur_valid[i] = 1'b0;
                end
                if (!cur_valid[i] && src_q[i].size() > 0) begin
                    ent = src_q[i].pop_front();
                    if (ent.gap != 8'd0) begin
                        ent.gap = ent.gap - 8'd1;
                    end else begin
                        cur_valid[i] = 1'b1;
                        cur_data[i]  = ent.data;
                    end
                    src_q[i].push_front(ent);
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            check("req_ready_onehot0", 64'($onehot0(bus.req_ready)), 64'd1);
            if (bus.buf_valid && bus.buf_ready) begin
                acc_cnt++;
                if (meas_on) begin
                    if (first_acc < 0) first_acc = cyc;
                    last_acc = cyc;
                end
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL beat_unexpected: got %0h, expected no beat (t=%0t)", bus.buf_data, $time);
                end else begin
                    check("beat_data", 64'(bus.buf_data), 64'(exp_q.pop_front()));
                end
            end
            if (bus.buf_out_valid) begin
                if (gid_q.size() == 0) begin
                    n_checks++;
                    n_fails++;
                    $display("FAIL grp_unexpected: got grp_id %0d, expected no group (t=%0t)", bus.grp_id, $time);
                end else begin
                    check("grp_id", 64'(bus.grp_id), 64'(gid_q[0]));
                    if (bus.buf_out_ready) void'(gid_q.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic load(input int s, input logic [DW-1:0] d, input int gap);
        beat_t b;
        b.data = d;
        b.gap  = 8'(gap);
        src_q[s].push_back(b);
    endtask

    function automatic bit pending();
        bit p;
        p = bus.busy || (exp_q.size() != 0) || (gid_q.size() != 0) || (bm_cnt != 0);
        for (int i = 0; i < NREQ; i++) if (src_q[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (pending() && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, 64'(pending()), 64'd0);
    endtask

    task automatic wait_acc(input string name, input int target, input int budget);
        int k = 0;
        while (acc_cnt < target && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, 64'(acc_cnt >= target), 64'd1);
    endtask

    task automatic wait_full(input string name, input int budget);
        int k = 0;
        while (!bus.buf_out_valid && k < budget) begin
            @(negedge clk);
            #1;
            k++;
        end
        check(name, 64'(bus.buf_out_valid), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int start;
        stall     = 1'b0;
        drain     = 1'b0;
        bm_cnt    = 0;
        cur_valid = '0;
        for (int i = 0; i < NREQ; i++) cur_data[i] = '0;
        n_checks  = 0;
        n_fails   = 0;
        acc_cnt   = 0;
        cyc       = 0;
        first_acc = -1;
        last_acc  = -1;
        meas_on   = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_buf_valid", 64'(bus.buf_valid), 64'd0);
        check("rst_buf_data", 64'(bus.buf_data), 64'd0);
        check("rst_grp_id", 64'(bus.grp_id), 64'd0);
        rstn = 1'b1;

        // Single source: src2 sends A,B back to back; buffer held full before draining
        @(posedge clk);
        #1;
        first_acc = -1;
        meas_on   = 1'b1;
        load(2, mk(2, 2, 0), 0);
        load(2, mk(2, 2, 1), 0);
        exp_q.push_back(mk(2, 2, 0));
        exp_q.push_back(mk(2, 2, 1));
        gid_q.push_back(2'd2);
        wait_full("t2_full_timeout", 50);
        repeat (3) @(negedge clk);
        #1;
        meas_on = 1'b0;
        check("t2_busy_fell", 64'(bus.busy), 64'd0);
        check("t2_beat_spacing", 64'(last_acc - first_acc), 64'd1);
        @(posedge clk);
        #1;
        drain = 1'b1;
        wait_drain("t2_drain_timeout", 50);

        // Reset in the middle of a burst (src3 has one beat accepted)
        load(3, mk(1, 3, 0), 0);
        load(3, mk(1, 3, 1), 20);
        exp_q.push_back(mk(1, 3, 0));
        start = acc_cnt;
        wait_acc("t1_first_beat_timeout", start + 1, 50);
        repeat (2) @(negedge clk);
        #1;
        check("t1_busy_before_rst", 64'(bus.busy), 64'd1);
        #2;
        rstn = 1'b0;
        #1;
        check("t1_rst_busy", 64'(bus.busy), 64'd0);
        check("t1_rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("t1_rst_buf_valid", 64'(bus.buf_valid), 64'd0);
        check("t1_rst_grp_id", 64'(bus.grp_id), 64'd0);
        for (int i = 0; i < NREQ; i++) src_q[i].delete();
        cur_valid = '0;
        exp_q.delete();
        gid_q.delete();
        bm_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;

        // Fairness: all four sources valid together; rr_ptr restarted at 0 by reset
        first_acc = -1;
        meas_on   = 1'b1;
        for (int b = 0; b < 4; b++) load(0, mk(3, 0, b), 0);
        for (int s = 1; s < NREQ; s++) begin
            load(s, mk(3, s, 0), 0);
            load(s, mk(3, s, 1), 0);
        end
        for (int s = 0; s < NREQ; s++) begin
            exp_q.push_back(mk(3, s, 0));
            exp_q.push_back(mk(3, s, 1));
            gid_q.push_back(IDW'(s));
        end
        exp_q.push_back(mk(3, 0, 2));
        exp_q.push_back(mk(3, 0, 3));
        gid_q.push_back(2'd0);
        wait_drain("t3_drain_timeout", 100);
        meas_on = 1'b0;
        // five groups, two beats each, one bubble per group: first to last beat spans 13 cycles
        check("t3_throughput_span", 64'(last_acc - first_acc), 64'd13);

        // Lock: src1 pauses between its beats; src0/src3 wait despite being valid
        load(1, mk(4, 1, 0), 0);
        load(1, mk(4, 1, 1), 5);
        load(0, mk(4, 0, 0), 0);
        load(0, mk(4, 0, 1), 0);
        load(3, mk(4, 3, 0), 0);
        load(3, mk(4, 3, 1), 0);
        exp_q.push_back(mk(4, 1, 0));
        exp_q.push_back(mk(4, 1, 1));
        exp_q.push_back(mk(4, 3, 0));
        exp_q.push_back(mk(4, 3, 1));
        exp_q.push_back(mk(4, 0, 0));
        exp_q.push_back(mk(4, 0, 1));
        gid_q.push_back(2'd1);
        gid_q.push_back(2'd3);
        gid_q.push_back(2'd0);
        start = acc_cnt;
        wait_acc("t4_first_beat_timeout", start + 1, 50);
        repeat (3) @(negedge clk);
        #1;
        check("t4_lock_busy", 64'(bus.busy), 64'd1);
        check("t4_lock_buf_valid", 64'(bus.buf_valid), 64'd0);
        wait_drain("t4_drain_timeout", 100);

        // Backpressure on the second beat of src2
        load(2, mk(5, 2, 0), 0);
        load(2, mk(5, 2, 1), 0);
        exp_q.push_back(mk(5, 2, 0));
        exp_q.push_back(mk(5, 2, 1));
        gid_q.push_back(2'd2);
        start = acc_cnt;
        wait_acc("t5_first_beat_timeout", start + 1, 50);
        @(posedge clk);
        #1;
        stall = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t5_stall_req_ready", 64'(bus.req_ready), 64'd0);
            check("t5_stall_buf_valid", 64'(bus.buf_valid), 64'd1);
            check("t5_stall_buf_data", 64'(bus.buf_data), 64'(mk(5, 2, 1)));
        end
        @(posedge clk);
        #1;
        stall = 1'b0;
        wait_drain("t5_drain_timeout", 50);

        // Overlap: buffer full with src1's group while src3's first beat goes in
        drain = 1'b0;
        load(1, mk(6, 1, 0), 0);
        load(1, mk(6, 1, 1), 0);
        exp_q.push_back(mk(6, 1, 0));
        exp_q.push_back(mk(6, 1, 1));
        gid_q.push_back(2'd1);
        start = acc_cnt;
        wait_acc("t6_src1_timeout", start + 2, 50);
        load(3, mk(6, 3, 0), 0);
        load(3, mk(6, 3, 1), 0);
        exp_q.push_back(mk(6, 3, 0));
        exp_q.push_back(mk(6, 3, 1));
        gid_q.push_back(2'd3);
        repeat (4) @(negedge clk);
        #1;
        check("t6_full_buf_valid", 64'(bus.buf_valid), 64'd1);
        check("t6_full_buf_ready", 64'(bus.buf_ready), 64'd0);
        check("t6_full_grp_id", 64'(bus.grp_id), 64'd1);
        @(posedge clk);
        #1;
        drain = 1'b1;
        @(negedge clk);
        #1;
        check("t6_overlap_buf_ready", 64'(bus.buf_ready), 64'd1);
        check("t6_overlap_grp_id", 64'(bus.grp_id), 64'd1);
        @(posedge clk);
        #1;
        drain = 1'b0;
        wait_full("t6_refill_timeout", 50);
        check("t6_new_grp_id", 64'(bus.grp_id), 64'd3);
        @(posedge clk);
        #1;
        drain = 1'b1;
        wait_drain("t6_drain_timeout", 50);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
